// File: rtl/coeff_load_ctrl_pkg.sv
// Shared constants, state encoding and default kernel for the
// frame-synchronous 3x3 coefficient loader.
package coeff_load_ctrl_pkg;

  localparam int NCOEFF     = 9;
  localparam int COEFF_W    = 16;
  localparam int IDX_W      = 4;
  localparam int COMMIT_IDX = NCOEFF;

  localparam logic [COEFF_W-1:0] CENTER_RST = 16'h0001;

  typedef logic [COEFF_W-1:0] coeff_t;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    LOAD,
    DONE
  } state_t;

  function automatic coeff_t dflt_coeff(input int i);
    return (i == NCOEFF / 2) ? CENTER_RST : '0;
  endfunction

endpackage

// File: rtl/coeff_load_ctrl_strobe_sync.sv
// Two-flop synchroniser for an async strobe level, rising-edge
// detect on the third flop and a toggle acknowledge.
module strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic strobe_i,
  output logic edge_o,
  output logic ack_o
);

  logic [2:0] sync_q;

  assign edge_o = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      ack_o  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], strobe_i};
      ack_o  <= ack_o ^ edge_o;
    end
  end

endmodule

// File: rtl/coeff_load_ctrl.sv
// Shadow/active coefficient banks, streamed to the conv stage at vsync.
// Define COEFF_READBACK_EN to add the rd_strobe_i/rd_ack_o/rd_data_o port.
module coeff_load_ctrl
  import coeff_load_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               vs_i,
  input  logic               wr_strobe_i,
  input  logic [7:0]         addr_i,
  input  logic [31:0]        data_i,
`ifdef COEFF_READBACK_EN
  input  logic               rd_strobe_i,
  output logic               rd_ack_o,
  output logic [31:0]        rd_data_o,
`endif
  output logic               wr_ack_o,
  output logic [COEFF_W-1:0] coeff_o,
  output logic               coeff_vld_o,
  output logic               coeff_first_o,
  output logic               busy_o,
  output logic               pending_o,
  output logic [7:0]         load_cnt_o
);

  state_t            state;
  coeff_t            shadow [NCOEFF];
  coeff_t            active [NCOEFF];
  logic [IDX_W-1:0]  cnt;
  logic [5:0]        idx;
  logic              wr_edge;
  logic              vs_q;
  logic              vs_rise;
  logic              commit;
  logic              unused_bits;

  assign idx         = addr_i[7:2];
  assign vs_rise     = vs_i & ~vs_q;
  assign commit      = wr_edge & (idx == 6'(COMMIT_IDX)) & data_i[0];
  assign busy_o      = (state == COPY) | (state == LOAD);
  assign unused_bits = ^{addr_i[1:0], data_i[31:COEFF_W]};

  strobe_sync u_wr_sync (
    .clk      (clk),
    .rst      (rst),
    .strobe_i (wr_strobe_i),
    .edge_o   (wr_edge),
    .ack_o    (wr_ack_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCOEFF; i++)
        shadow[i] <= dflt_coeff(i);
    end else if (wr_edge && idx < 6'(NCOEFF)) begin
      shadow[idx[IDX_W-1:0]] <= data_i[COEFF_W-1:0];
    end
  end

  // COPY already issues word 0 so the stream starts two cycles after the rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      vs_q          <= 1'b0;
      pending_o     <= 1'b1;
      cnt           <= '0;
      coeff_o       <= '0;
      coeff_vld_o   <= 1'b0;
      coeff_first_o <= 1'b0;
      load_cnt_o    <= '0;
      for (int i = 0; i < NCOEFF; i++)
        active[i] <= dflt_coeff(i);
    end else begin
      vs_q <= vs_i;
      unique case (state)
        IDLE: begin
          if (vs_rise && pending_o)
            state <= COPY;
        end
        COPY: begin
          for (int i = 0; i < NCOEFF; i++)
            active[i] <= shadow[i];
          pending_o     <= 1'b0;
          coeff_o       <= shadow[0];
          coeff_vld_o   <= 1'b1;
          coeff_first_o <= 1'b1;
          cnt           <= IDX_W'(1);
          state         <= LOAD;
        end
        LOAD: begin
          coeff_o       <= active[cnt];
          coeff_vld_o   <= 1'b1;
          coeff_first_o <= (cnt == '0);
          cnt           <= cnt + 1'b1;
          if (cnt == IDX_W'(NCOEFF - 1))
            state <= DONE;
        end
        DONE: begin
          coeff_vld_o   <= 1'b0;
          coeff_first_o <= 1'b0;
          load_cnt_o    <= load_cnt_o + 8'd1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (commit)
        pending_o <= 1'b1;
    end
  end

`ifdef COEFF_READBACK_EN
  logic rd_edge;

  strobe_sync u_rd_sync (
    .clk      (clk),
    .rst      (rst),
    .strobe_i (rd_strobe_i),
    .edge_o   (rd_edge),
    .ack_o    (rd_ack_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_o <= '0;
    end else if (rd_edge) begin
      if (idx < 6'(NCOEFF))
        rd_data_o <= 32'(active[idx[IDX_W-1:0]]);
      else if (idx == 6'(COMMIT_IDX))
        rd_data_o <= {31'b0, pending_o};
      else
        rd_data_o <= '0;
    end
  end
`endif

endmodule
